vga_pixel_writer: RTL and testbench

//   Consumes the CPU's memory-mapped VGA register writes (x, y, colour, write strobe).

---
 rtl/vga_pw_pkg.sv | 30 +++
 rtl/vga_pixel_writer_if.sv | 30 +++
 rtl/pw_cmd_fifo.sv | 50 +++++
 rtl/vga_pixel_writer.sv | 165 ++++++++++++++++
 tb/tb_vga_pixel_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pw_pkg.sv
// Shared types and defaults for the VGA pixel writer: screen geometry,
// the command record queued between the MMIO bank and the draw FSM,
// and the draw FSM state encoding.
package vga_pw_pkg;

  localparam int PW_H_RES    = 160;
  localparam int PW_V_RES    = 120;
  localparam int PW_COLOUR_W = 9;
  localparam int PW_ADDR_W   = 15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW
  } pw_state_t;

  typedef struct packed {
    logic [15:0]            x;
    logic [15:0]            y;
    logic [7:0]             w;
    logic [7:0]             h;
    logic [PW_COLOUR_W-1:0] colour;
  } pw_cmd_t;

  // Index of the last column/row of an extent; an extent of 0 draws as 1.
  function automatic logic [7:0] last_idx(input logic [7:0] n);
    return (n == 8'd0) ? 8'd0 : n - 8'd1;
  endfunction

endpackage

// File: rtl/vga_pixel_writer_if.sv
// Command and framebuffer-write signal bundle of the VGA pixel writer.
// master: CPU register bank / framebuffer side; slave: the pixel writer.
interface vga_pixel_writer_if #(
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [15:0]         cmd_x;
  logic [15:0]         cmd_y;
  logic [7:0]          cmd_w;
  logic [7:0]          cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_data;
  logic                fb_ready;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, fb_ready,
    input  cmd_ready, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, fb_ready,
    output cmd_ready, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/pw_cmd_fifo.sv
// Synchronous command FIFO for the pixel writer. Pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
// DEPTH must be a power of two, at least 2.
module pw_cmd_fifo
  import vga_pw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    push,
  input  logic    pop,
  input  pw_cmd_t din,
  output pw_cmd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  pw_cmd_t     mem [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Entry storage; payload only, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_pixel_writer.sv
// VGA pixel writer: queues CPU plot/fill commands and replays them as
// framebuffer writes in raster order, one pixel per accepted fb_ready.
// Optional build macro VGA_PW_CLIP_EN: suppress writes to off-screen pixels
// (they still take one cycle each). Without it every pixel is written and
// off-screen coordinates alias through the truncated address.
module vga_pixel_writer
  import vga_pw_pkg::*;
#(
  parameter int H_RES      = PW_H_RES,
  parameter int V_RES      = PW_V_RES,
  parameter int COLOUR_W   = PW_COLOUR_W,
  parameter int ADDR_W     = PW_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  vga_pixel_writer_if.slave   bus,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

`ifdef VGA_PW_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  pw_state_t         state;
  pw_state_t         state_nx;
  pw_cmd_t           fifo_din;
  pw_cmd_t           fifo_dout;
  pw_cmd_t           cmd_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              we_c;
  logic [7:0]        cx;
  logic [7:0]        cy;
  logic [7:0]        w_last;
  logic [7:0]        h_last;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       col_abs;
  logic [31:0]       row_abs;
  logic              on_screen;
  logic              pix_en;
  logic              step;
  logic              drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fifo_din.x      = bus.cmd_x;
  assign fifo_din.y      = bus.cmd_y;
  assign fifo_din.w      = bus.cmd_w;
  assign fifo_din.h      = bus.cmd_h;
  assign fifo_din.colour = PW_COLOUR_W'(bus.cmd_colour);

  pw_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (bus.cmd_valid),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign w_last   = last_idx(cmd_q.w);
  assign h_last   = last_idx(cmd_q.h);
  assign last_col = (cx == w_last);
  assign last_row = (cy == h_last);

  // Start address is the only multiply; later rows step the base by H_RES.
  assign base_addr = ADDR_W'({16'b0, cmd_q.y} * 32'(H_RES) + {16'b0, cmd_q.x});

  assign col_abs   = {16'b0, cmd_q.x} + {24'b0, cx};
  assign row_abs   = {16'b0, cmd_q.y} + {24'b0, cy};
  assign on_screen = (col_abs < 32'(H_RES)) && (row_abs < 32'(V_RES));
  assign pix_en    = on_screen || !CLIP_EN;

  // Suppressed pixels advance without waiting for the framebuffer.
  assign step = (state == DRAW) && (bus.fb_ready || !pix_en);
  assign drop = bus.cmd_valid && fifo_full && !pop;

  assign bus.cmd_ready = !fifo_full;
  assign bus.fb_we     = we_c;
  assign bus.fb_addr   = row_base + ADDR_W'(cx);
  assign bus.fb_data   = COLOUR_W'(cmd_q.colour);
  assign busy          = !fifo_empty || (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state, FIFO pop and write request.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    we_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = DRAW;
      DRAW: begin
        we_c = pix_en;
        if (step && last_col && last_row) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, pixel counters and row base address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q    <= '0;
      cx       <= 8'd0;
      cy       <= 8'd0;
      row_base <= '0;
    end else begin
      if (pop) cmd_q <= fifo_dout;
      if (state == LOAD) begin
        row_base <= base_addr;
        cx       <= 8'd0;
        cy       <= 8'd0;
      end else if (step) begin
        if (last_col) begin
          cx <= 8'd0;
          if (!last_row) begin
            cy       <= cy + 8'd1;
            row_base <= row_base + ADDR_W'(H_RES);
          end
        end else begin
          cx <= cx + 8'd1;
        end
      end
    end
  end

  // Count commands lost to a full FIFO, saturating.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   drop_cnt <= 8'd0;
    else if (drop) drop_cnt <= sat_inc8(drop_cnt);
  end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Self-checking bench for vga_pixel_writer. The reference model expands each
// accepted command into its list of (address, colour) writes in raster order.
module tb_vga_pixel_writer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       busy;
  logic [7:0] drop_cnt;

  vga_pixel_writer_if bus ();

  vga_pixel_writer dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   rdy_mode    = 0;   // 0: ready, 1: toggle, 2: random, 3: stalled
  int   stall_err   = 0;
  wr_t  got_q[$];
  int   exp_addr[$];
  int   exp_data[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.fb_ready = 1'b1;
      1:       bus.fb_ready = ~bus.fb_ready;
      2:       bus.fb_ready = 1'($urandom_range(0, 1));
      default: bus.fb_ready = 1'b0;
    endcase
  end

  // Write log plus hold-stable check across stall cycles.
  initial begin
    logic prev_stall;
    int   prev_addr, prev_data;
    wr_t  w;
    prev_stall = 1'b0;
    prev_addr  = 0;
    prev_data  = 0;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        if (prev_stall && !(bus.fb_we === 1'b1 && int'(bus.fb_addr) == prev_addr &&
                            int'(bus.fb_data) == prev_data))
          stall_err++;
        if (bus.fb_we === 1'b1 && bus.fb_ready === 1'b1) begin
          w.addr = int'(bus.fb_addr);
          w.data = int'(bus.fb_data);
          w.cyc  = cyc;
          got_q.push_back(w);
        end
        prev_stall = (bus.fb_we === 1'b1) && (bus.fb_ready === 1'b0);
        prev_addr  = int'(bus.fb_addr);
        prev_data  = int'(bus.fb_data);
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic model_cmd(input int x, input int y, input int w, input int h, input int col);
    int we = (w == 0) ? 1 : w;
    int he = (h == 0) ? 1 : h;
    for (int r = 0; r < he; r++) begin
      for (int c = 0; c < we; c++) begin
        int xa = x + c;
        int ya = y + r;
`ifdef VGA_PW_CLIP_EN
        if (xa >= 160 || ya >= 120) continue;
`endif
        exp_addr.push_back((ya * 160 + xa) % 32768);
        exp_data.push_back(col);
      end
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_addr.delete();
    exp_data.delete();
    stall_err = 0;
  endtask

  // One-cycle strobe; returns the cycle number of the capturing edge.
  task automatic push_cmd(input int x, input int y, input int w, input int h, input int col,
                          output int pcyc);
    bus.cmd_x      = 16'(x);
    bus.cmd_y      = 16'(y);
    bus.cmd_w      = 8'(w);
    bus.cmd_h      = 8'(h);
    bus.cmd_colour = 9'(col);
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    pcyc          = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_x      = '0;
    bus.cmd_y      = '0;
    bus.cmd_w      = '0;
    bus.cmd_h      = '0;
    bus.cmd_colour = '0;
    bus.fb_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    vectors++; if (bus.fb_we !== 1'b0) begin miscompares++; $display("FAIL reset_fb_we: got %b expected 0", bus.fb_we); end
    vectors++; if (bus.fb_addr !== 15'd0) begin miscompares++; $display("FAIL reset_fb_addr: got %0d expected 0", bus.fb_addr); end
    vectors++; if (bus.fb_data !== 9'd0) begin miscompares++; $display("FAIL reset_fb_data: got %0h expected 0", bus.fb_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pixel();
    int p;
    rdy_mode = 0;
    clear_logs();
    model_cmd(5, 3, 0, 0, 'h1FF);
    push_cmd(5, 3, 0, 0, 'h1FF, p);
    repeat (3) @(negedge clk);
    vectors++; if (bus.fb_we !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL single_we_at_2: got we=%b busy=%b expected we=1 busy=1", bus.fb_we, busy); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || bus.fb_we !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: got busy=%b we=%b expected 0 0", busy, bus.fb_we); end
    @(posedge clk);
    #1;
    vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      vectors++; if (got_q[0].addr != exp_addr[0] || got_q[0].data != exp_data[0]) begin miscompares++; $display("FAIL single_write: got %0d/%0h expected %0d/%0h", got_q[0].addr, got_q[0].data, exp_addr[0], exp_data[0]); end
      vectors++; if (got_q[0].cyc != p + 2) begin miscompares++; $display("FAIL single_latency: got cycle %0d expected %0d", got_q[0].cyc, p + 2); end
    end
  endtask

  task automatic test_rect(input int mode, input string nm);
    int p;
    bit ok;
    rdy_mode = mode;
    clear_logs();
    model_cmd(10, 20, 3, 2, 'h0A5);
    push_cmd(10, 20, 3, 2, 'h0A5, p);
    wait_idle(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_timeout: got busy expected idle", nm); end
    vectors++; if (got_q.size() != exp_addr.size()) begin miscompares++; $display("FAIL %s_count: got %0d expected %0d", nm, got_q.size(), exp_addr.size()); end
    for (int i = 0; i < got_q.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (got_q[i].addr != exp_addr[i] || got_q[i].data != exp_data[i]) begin
        miscompares++; $display("FAIL %s_pixel%0d: got %0d/%0h expected %0d/%0h", nm, i, got_q[i].addr, got_q[i].data, exp_addr[i], exp_data[i]);
      end
      if (mode == 0 && i > 0) begin
        vectors++;
        if (got_q[i].cyc != got_q[i-1].cyc + 1) begin miscompares++; $display("FAIL %s_consecutive%0d: got cycle %0d expected %0d", nm, i, got_q[i].cyc, got_q[i-1].cyc + 1); end
      end
    end
    vectors++; if (stall_err != 0) begin miscompares++; $display("FAIL %s_stall_stable: got %0d unstable stalls expected 0", nm, stall_err); end
  endtask

  task automatic test_back_to_back();
    int p;
    bit ok;
    rdy_mode = 0;
    clear_logs();
    model_cmd(0, 0, 2, 1, 'h011);
    model_cmd(50, 50, 1, 1, 'h022);
    push_cmd(0, 0, 2, 1, 'h011, p);
    push_cmd(50, 50, 1, 1, 'h022, p);
    wait_idle(100, ok);
    vectors++; if (!ok || got_q.size() != 3) begin miscompares++; $display("FAIL b2b_count: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (got_q[i].addr != exp_addr[i] || got_q[i].data != exp_data[i]) begin miscompares++; $display("FAIL b2b_pixel%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].addr, got_q[i].data, exp_addr[i], exp_data[i]); end
    end
    if (got_q.size() == 3) begin
      vectors++; if (got_q[2].cyc != got_q[1].cyc + 2) begin miscompares++; $display("FAIL b2b_bubble: got cycle %0d expected %0d", got_q[2].cyc, got_q[1].cyc + 2); end
    end
  endtask

  task automatic test_overflow();
    int p;
    bit ok;
    rdy_mode = 3;
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) model_cmd(i, 1, 1, 1, 16 + i);
      push_cmd(i, 1, 1, 1, 16 + i, p);
    end
    @(negedge clk);
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("FAIL ovf_drop_cnt: got %0d expected 1", drop_cnt); end
    vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_cmd_ready: got %b expected 0", bus.cmd_ready); end
    vectors++; if (bus.fb_we !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL ovf_holding: got we=%b busy=%b expected 1 1", bus.fb_we, busy); end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    wait_idle(200, ok);
    vectors++; if (!ok || got_q.size() != 5) begin miscompares++; $display("FAIL ovf_drawn: got %0d expected 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (got_q[i].addr != exp_addr[i] || got_q[i].data != exp_data[i]) begin miscompares++; $display("FAIL ovf_pixel%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].addr, got_q[i].data, exp_addr[i], exp_data[i]); end
    end
    vectors++; if (stall_err != 0) begin miscompares++; $display("FAIL ovf_stall_stable: got %0d expected 0", stall_err); end
  endtask

  task automatic test_drop_saturate();
    int p;
    bit ok;
    rdy_mode = 3;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      model_cmd(i, 7, 1, 1, 40 + i);
      push_cmd(i, 7, 1, 1, 40 + i, p);
    end
    bus.cmd_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt); end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    wait_idle(200, ok);
    vectors++; if (!ok || got_q.size() != 5) begin miscompares++; $display("FAIL sat_drawn: got %0d expected 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (got_q[i].addr != exp_addr[i] || got_q[i].data != exp_data[i]) begin miscompares++; $display("FAIL sat_pixel%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].addr, got_q[i].data, exp_addr[i], exp_data[i]); end
    end
  endtask

  task automatic test_clip();
    int p;
    bit ok;
    rdy_mode = 0;
    clear_logs();
    model_cmd(158, 119, 4, 2, 'h155);
    push_cmd(158, 119, 4, 2, 'h155, p);
    wait_idle(100, ok);
    vectors++; if (!ok || got_q.size() != exp_addr.size()) begin miscompares++; $display("FAIL clip_count: got %0d expected %0d", got_q.size(), exp_addr.size()); end
    for (int i = 0; i < got_q.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (got_q[i].addr != exp_addr[i] || got_q[i].data != exp_data[i]) begin miscompares++; $display("FAIL clip_pixel%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].addr, got_q[i].data, exp_addr[i], exp_data[i]); end
    end
  endtask

  task automatic test_random();
    int p, n;
    bit ok;
    rdy_mode = 2;
    clear_logs();
    for (int k = 0; k < 25; k++) begin
      int x   = int'($urandom_range(0, 170));
      int y   = int'($urandom_range(0, 130));
      int w   = int'($urandom_range(0, 4));
      int h   = int'($urandom_range(0, 3));
      int col = int'($urandom_range(0, 511));
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 500) begin
        @(posedge clk);
        #1;
        n++;
      end
      model_cmd(x, y, w, h, col);
      push_cmd(x, y, w, h, col, p);
    end
    wait_idle(3000, ok);
    vectors++; if (!ok || got_q.size() != exp_addr.size()) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_addr.size()); end
    for (int i = 0; i < got_q.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (got_q[i].addr != exp_addr[i] || got_q[i].data != exp_data[i]) begin miscompares++; $display("FAIL rand_pixel%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].addr, got_q[i].data, exp_addr[i], exp_data[i]); end
    end
    vectors++; if (stall_err != 0) begin miscompares++; $display("FAIL rand_stall_stable: got %0d expected 0", stall_err); end
    vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("FAIL rand_no_drop: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    int p, n;
    bit ok;
    rdy_mode = 0;
    clear_logs();
    push_cmd(20, 30, 8, 8, 'h0F0, p);
    n = 0;
    while (got_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL rst_mid_reach: got %0d writes expected 2", got_q.size()); end
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    vectors++; if (bus.fb_we !== 1'b0) begin miscompares++; $display("FAIL rst_mid_we: got %b expected 0", bus.fb_we); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_mid_drop: got %0d expected 0", drop_cnt); end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    model_cmd(1, 2, 2, 2, 'h033);
    push_cmd(1, 2, 2, 2, 'h033, p);
    wait_idle(100, ok);
    vectors++; if (!ok || got_q.size() != 4) begin miscompares++; $display("FAIL rst_after_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (got_q[i].addr != exp_addr[i] || got_q[i].data != exp_data[i]) begin miscompares++; $display("FAIL rst_after_pixel%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].addr, got_q[i].data, exp_addr[i], exp_data[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_rect(0, "rect");
    test_rect(1, "backpressure");
    test_back_to_back();
    test_overflow();
    test_drop_saturate();
    test_clip();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
